// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Optional performance counters are enabled with FETCH_PERF_CNT_EN.
package fetch_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_INSTR_W = 8;
    localparam logic [7:0] DEF_HALT_OPCODE = 8'hFF;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] all_ones;
        all_ones = {CNT_W{1'b1}};
        return (value == all_ones) ? value : value + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory, hazard unit and decode.
// Counter signals exist only when FETCH_PERF_CNT_EN is defined.
interface fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
);
    logic               run;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_instr;
    logic               stall;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] id_instr;
    logic [ADDR_W-1:0]  id_pc;
    logic               id_valid;
    logic               halted;
`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0]   fetch_cnt;
    logic [CNT_W-1:0]   stall_cnt;
`endif

    modport master (
        input  run, imem_instr, stall, redirect, redirect_pc,
        output imem_addr, pc, id_instr, id_pc, id_valid, halted
`ifdef FETCH_PERF_CNT_EN
        , output fetch_cnt, stall_cnt
`endif
    );

    modport slave (
        output run, imem_instr, stall, redirect, redirect_pc,
        input  imem_addr, pc, id_instr, id_pc, id_valid, halted
`ifdef FETCH_PERF_CNT_EN
        , input fetch_cnt, stall_cnt
`endif
    );

endinterface

// File: rtl/fetch_perf_cnt.sv
// Saturating event counter with enable, cleared only by reset.
module fetch_perf_cnt
    import fetch_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_r;

    // Count enabled cycles, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (en && (cnt_r != {W{1'b1}})) begin
            cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch controller: owns the PC, reads async imem, fills IF/ID.
// Define FETCH_PERF_CNT_EN to add the fetch/stall performance counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                 ADDR_W      = DEF_ADDR_W,
    parameter int                 INSTR_W     = DEF_INSTR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC    = {ADDR_W{1'b0}},
    parameter logic [INSTR_W-1:0] HALT_OPCODE = INSTR_W'(DEF_HALT_OPCODE)
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_FETCH = ST_FETCH;
    localparam logic [1:0] S_HALT  = ST_HALT;
    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]         state_r;
    logic [ADDR_W-1:0]  pc_r;
    logic [INSTR_W-1:0] id_instr_r;
    logic [ADDR_W-1:0]  id_pc_r;
    logic               id_valid_r;
    logic               halted_r;
    logic               is_halt_s;

    // Decode of the byte currently returned by instruction memory.
    always_comb begin
        is_halt_s = 1'b0;
        if (bus.imem_instr == HALT_OPCODE) begin
            is_halt_s = 1'b1;
        end else begin
            is_halt_s = 1'b0;
        end
    end

    // State machine, PC and IF/ID register; redirect outranks stall everywhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            pc_r       <= RESET_PC;
            id_instr_r <= {INSTR_W{1'b0}};
            id_pc_r    <= {ADDR_W{1'b0}};
            id_valid_r <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    id_valid_r <= 1'b0;
                    if (bus.run) begin
                        state_r <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (bus.redirect) begin
                        pc_r       <= bus.redirect_pc;
                        id_valid_r <= 1'b0;
                    end else if (!bus.stall) begin
                        id_instr_r <= bus.imem_instr;
                        id_pc_r    <= pc_r;
                        id_valid_r <= 1'b1;
                        if (is_halt_s) begin
                            state_r  <= S_HALT;
                            halted_r <= 1'b1;
                        end else begin
                            pc_r <= pc_r + PC_ONE;
                        end
                    end
                end
                S_HALT: begin
                    // A redirect here comes from an older branch, so the HALT was speculative.
                    if (bus.redirect) begin
                        pc_r       <= bus.redirect_pc;
                        id_valid_r <= 1'b0;
                        state_r    <= S_FETCH;
                        halted_r   <= 1'b0;
                    end else if (!bus.stall) begin
                        id_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= S_IDLE;
                    id_valid_r <= 1'b0;
                    halted_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_addr = pc_r;
    assign bus.pc        = pc_r;
    assign bus.id_instr  = id_instr_r;
    assign bus.id_pc     = id_pc_r;
    assign bus.id_valid  = id_valid_r;
    assign bus.halted    = halted_r;

`ifdef FETCH_PERF_CNT_EN
    logic             fetch_en_s;
    logic             stall_en_s;
    logic [CNT_W-1:0] fetch_cnt_s;
    logic [CNT_W-1:0] stall_cnt_s;

    // Count IF/ID loads and stalled FETCH cycles that are not overridden by redirect.
    always_comb begin
        fetch_en_s = 1'b0;
        stall_en_s = 1'b0;
        if (state_r == S_FETCH && !bus.redirect) begin
            fetch_en_s = !bus.stall;
            stall_en_s = bus.stall;
        end else begin
            fetch_en_s = 1'b0;
            stall_en_s = 1'b0;
        end
    end

    fetch_perf_cnt #(.W(CNT_W)) u_fetch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (fetch_en_s),
        .cnt   (fetch_cnt_s)
    );

    fetch_perf_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stall_en_s),
        .cnt   (stall_cnt_s)
    );

    assign bus.fetch_cnt = fetch_cnt_s;
    assign bus.stall_cnt = stall_cnt_s;
`endif

endmodule
